image_frame_parser: RTL and testbench
=====================================

Name: image_frame_parser

Overview:
- Framing stage between the UART byte receiver and the pixel RAM.
- Consumes the raw byte stream (one-cycle `rx_valid` strobes) and hunts for a sync header.
- Validates a 24-bit payload length, writes payload bytes to sequential RAM addresses from 0, and checks an 8-bit additive checksum.
- Ends each frame with a `frame_done` or `frame_err` pulse; `image_ready` tells the inference trigger that a complete, verified image is in RAM.

Parameters:
- ADDR_W, 18, width of `wr_addr`; must hold MAX_BYTES-1.
- MAX_BYTES, 150528, largest legal payload length (224x224x3).
- SYNC0, 8'hA5, first header byte.
- SYNC1, 8'h5A, second header byte.
- TIMEOUT_CYCLES, 1000000, idle clocks allowed between bytes inside a frame.
- TO_W, 20, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rx_data  in  8  received byte, valid only when rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte
- wr_en  out  1  pixel RAM write strobe
- wr_addr  out  ADDR_W  pixel RAM write address
- wr_data  out  8  pixel RAM write data
- frame_len  out  24  length of last accepted frame
- frame_done  out  1  one-cycle pulse: frame complete, checksum good
- frame_err  out  1  one-cycle pulse: frame aborted or bad
- err_code  out  2  0 none, 1 bad length, 2 checksum mismatch, 3 timeout
- image_ready  out  1  level: RAM holds a verified image
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; checksum accumulator, length register and timeout counter 0.
- All outputs are registered. Each output responds one clock after the rx_valid cycle that caused it.
- States and transitions (advance only on rx_valid unless noted):
  - IDLE: byte==SYNC0 -> SYNC, clear err_code; any other byte -> stay.
  - SYNC: byte==SYNC1 -> LEN2; byte==SYNC0 -> stay; other -> IDLE. No error is raised on sync failure.
  - LEN2, LEN1, LEN0: capture length MSB first.
  - On the LEN0 byte: if length==0 or length>MAX_BYTES -> IDLE, frame_err=1, err_code=1.
  - Otherwise -> PAYLOAD: frame_len=length, image_ready=0, byte counter=0, checksum=0.
- PAYLOAD, per byte:
  - wr_en=1, wr_addr=counter, wr_data=byte.
  - checksum += byte (mod 256); counter += 1.
  - On the byte where counter==length-1 -> CHECK.
- CHECK, on the checksum byte:
  - If byte==checksum: frame_done=1, image_ready=1, err_code=0.
  - Else: frame_err=1, err_code=2, image_ready stays 0.
  - Either way -> IDLE.
- wr_en is high for exactly `length` cycles per frame, never in any other state. wr_addr never exceeds MAX_BYTES-1.
- Timeout, active in SYNC through CHECK:
  - Counter clears on every rx_valid and increments on each clock without one.
  - When it reaches TIMEOUT_CYCLES-1 with rx_valid=0, the next edge goes -> IDLE with frame_err=1, err_code=3.
  - rx_valid in the expiry cycle wins: the byte is processed and no timeout occurs.
  - Counter is held at 0 in IDLE.
- frame_done and frame_err are never high together; each lasts one cycle.
- err_code holds until the next SYNC0 is accepted in IDLE.
- image_ready holds until the next valid length enters PAYLOAD.
- Reset mid-frame returns to IDLE at once and clears outputs. RAM contents are not the parser's concern.
- The next frame's SYNC0 may arrive on the very next rx_valid after CHECK. No dead cycles are required.

Test Plan:
- Good frame: A5 5A 00 00 04 01 02 03 04 0A -> wr_en at addr 0..3 with data 01..04; frame_done one pulse; image_ready=1; frame_len=4; err_code=0.
- Bad checksum: same frame but final byte 0B -> four writes occur; frame_err pulse; err_code=2; image_ready=0; frame_done never high.
- Illegal lengths:
  - A5 5A 00 00 00 -> frame_err, err_code=1, no wr_en.
  - A5 5A 02 4C 01 (150529) -> frame_err, err_code=1, no wr_en.
- Timeout: TIMEOUT_CYCLES=100; send header, length 4 and two payload bytes, then stop -> frame_err with err_code=3 in the cycle 100 edges after the last byte is sampled.
- Timeout race: same setup, but the next byte arrives exactly in the expiry cycle -> no error.
- Sync hunting:
  - 00 A5 3C A5 A5 5A 00 00 01 7F 7F -> one frame_done, one write of 7F at addr 0.
  - Reset asserted mid-payload -> busy=0 and all outputs 0 immediately.
  - A following good frame completes normally.

Source files
------------

// File: rtl/image_frame_parser.sv
// Byte-stream framing stage: hunts for a two-byte sync header, validates a 24-bit
// length, streams the payload into pixel RAM and verifies an 8-bit additive checksum.
module image_frame_parser #(
  parameter int          ADDR_W         = 18,
  parameter int          MAX_BYTES      = 150528,
  parameter logic [7:0]  SYNC0          = 8'hA5,
  parameter logic [7:0]  SYNC1          = 8'h5A,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter int          TO_W           = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [23:0]       frame_len,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        err_code,
  output logic              image_ready,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, SYNC, LEN2, LEN1, LEN0, PAYLOAD, CHECK} state_t;

  state_t            state_reg, state_next;
  logic [15:0]       len_hi_reg, len_hi_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [7:0]        csum_reg, csum_next;
  logic [TO_W-1:0]   to_reg, to_next;

  logic              wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [7:0]        wr_data_reg, wr_data_next;
  logic [23:0]       frame_len_reg, frame_len_next;
  logic              done_reg, done_next;
  logic              err_reg, err_next;
  logic [1:0]        err_code_reg, err_code_next;
  logic              ready_reg, ready_next;
  logic              busy_reg, busy_next;

  logic [23:0]       full_len;
  logic              last_byte;

  assign full_len  = {len_hi_reg, rx_data};
  assign last_byte = (24'(cnt_reg) == frame_len_reg - 24'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      len_hi_reg    <= '0;
      cnt_reg       <= '0;
      csum_reg      <= '0;
      to_reg        <= '0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      frame_len_reg <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      err_code_reg  <= '0;
      ready_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      len_hi_reg    <= len_hi_next;
      cnt_reg       <= cnt_next;
      csum_reg      <= csum_next;
      to_reg        <= to_next;
      wr_en_reg     <= wr_en_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      frame_len_reg <= frame_len_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
      err_code_reg  <= err_code_next;
      ready_reg     <= ready_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    len_hi_next    = len_hi_reg;
    cnt_next       = cnt_reg;
    csum_next      = csum_reg;
    to_next        = to_reg;
    wr_en_next     = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    frame_len_next = frame_len_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    err_code_next  = err_code_reg;
    ready_next     = ready_reg;

    if (state_reg == IDLE) begin
      to_next = '0;
      if (rx_valid && rx_data == SYNC0) begin
        state_next    = SYNC;
        err_code_next = 2'd0;
      end
    end else if (rx_valid) begin
      // A byte arriving in the expiry cycle takes priority over the timeout.
      to_next = '0;
      case (state_reg)
        SYNC: begin
          if (rx_data == SYNC1)      state_next = LEN2;
          else if (rx_data != SYNC0) state_next = IDLE;
        end
        LEN2: begin
          len_hi_next[15:8] = rx_data;
          state_next        = LEN1;
        end
        LEN1: begin
          len_hi_next[7:0] = rx_data;
          state_next       = LEN0;
        end
        LEN0: begin
          if (full_len == 24'd0 || full_len > 24'(MAX_BYTES)) begin
            state_next    = IDLE;
            err_next      = 1'b1;
            err_code_next = 2'd1;
          end else begin
            state_next     = PAYLOAD;
            frame_len_next = full_len;
            ready_next     = 1'b0;
            cnt_next       = '0;
            csum_next      = '0;
          end
        end
        PAYLOAD: begin
          wr_en_next   = 1'b1;
          wr_addr_next = cnt_reg;
          wr_data_next = rx_data;
          csum_next    = csum_reg + rx_data;
          cnt_next     = cnt_reg + ADDR_W'(1);
          if (last_byte) state_next = CHECK;
        end
        CHECK: begin
          state_next = IDLE;
          if (rx_data == csum_reg) begin
            done_next     = 1'b1;
            ready_next    = 1'b1;
            err_code_next = 2'd0;
          end else begin
            err_next      = 1'b1;
            err_code_next = 2'd2;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (to_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
      state_next    = IDLE;
      err_next      = 1'b1;
      err_code_next = 2'd3;
      to_next       = '0;
    end else begin
      to_next = to_reg + TO_W'(1);
    end

    busy_next = (state_next != IDLE);
  end

  assign wr_en       = wr_en_reg;
  assign wr_addr     = wr_addr_reg;
  assign wr_data     = wr_data_reg;
  assign frame_len   = frame_len_reg;
  assign frame_done  = done_reg;
  assign frame_err   = err_reg;
  assign err_code    = err_code_reg;
  assign image_ready = ready_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_image_frame_parser.sv
// Randomized scoreboard bench for image_frame_parser: a buffer-based frame model
// predicts writes and end-of-frame events with exact cycle stamps.
module tb_image_frame_parser;

  localparam int ADDR_W = 18;
  localparam int MAX_BYTES = 150528;
  localparam int TO = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic [23:0]       frame_len;
  logic              frame_done;
  logic              frame_err;
  logic [1:0]        err_code;
  logic              image_ready;
  logic              busy;

  image_frame_parser #(
    .ADDR_W(ADDR_W), .MAX_BYTES(MAX_BYTES), .SYNC0(8'hA5), .SYNC1(8'h5A),
    .TIMEOUT_CYCLES(TO), .TO_W(20)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_len(frame_len),
    .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code),
    .image_ready(image_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; int data; int cyc; } wr_t;
  typedef struct { int kind; int code; int cyc; int flen; int img; } ev_t; // kind 1 done, 2 err

  wr_t wq[$];
  ev_t eq[$];
  int  tests = 0;
  int  fails = 0;

  // Model: bytes of the frame attempt in progress (empty = hunting for sync).
  logic [7:0] fbuf[$];
  int m_len = 0, m_flen = 0, m_img = 0, last_edge = 0;

  task automatic push_ev(int kind, int code, int edge_c);
    ev_t e;
    e.kind = kind; e.code = code; e.cyc = edge_c; e.flen = m_flen; e.img = m_img;
    eq.push_back(e);
  endtask

  task automatic model_byte(logic [7:0] b, int edge_c);
    int idx, sum;
    wr_t w;
    if (fbuf.size() == 0) begin
      if (b == 8'hA5) fbuf.push_back(b);
    end else if (fbuf.size() == 1) begin
      if (b == 8'h5A) fbuf.push_back(b);
      else if (b != 8'hA5) fbuf.delete();
    end else if (fbuf.size() < 4) begin
      fbuf.push_back(b);
    end else if (fbuf.size() == 4) begin
      m_len = (int'(fbuf[2]) << 16) + (int'(fbuf[3]) << 8) + int'(b);
      if (m_len == 0 || m_len > MAX_BYTES) begin
        push_ev(2, 1, edge_c);
        fbuf.delete();
      end else begin
        fbuf.push_back(b);
        m_flen = m_len;
        m_img = 0;
      end
    end else begin
      idx = fbuf.size() - 5;
      if (idx < m_len) begin
        w.addr = idx; w.data = int'(b); w.cyc = edge_c;
        wq.push_back(w);
        fbuf.push_back(b);
      end else begin
        sum = 0;
        for (int i = 5; i < fbuf.size(); i++) sum += int'(fbuf[i]);
        if ((sum % 256) == int'(b)) begin
          m_img = 1;
          push_ev(1, 0, edge_c);
        end else begin
          push_ev(2, 2, edge_c);
        end
        fbuf.delete();
      end
    end
  endtask

  // Each driver task starts and ends on a falling edge.
  task automatic send_byte(logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    model_byte(b, cyc + 1);
    last_edge = cyc + 1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic tick_idle();
    rx_valid = 1'b0;
    if (fbuf.size() > 0 && cyc + 1 == last_edge + TO) begin
      push_ev(2, 3, cyc + 1);
      fbuf.delete();
    end
    @(negedge clk);
  endtask

  task automatic idle_n(int n);
    for (int i = 0; i < n; i++) tick_idle();
  endtask

  task automatic send_seq(logic [7:0] q[$], int gmax);
    foreach (q[i]) begin
      idle_n($urandom_range(0, gmax));
      send_byte(q[i]);
    end
  endtask

  task automatic check_zero(string name);
    tests++;
    if ({busy, wr_en, wr_addr, wr_data, frame_len, frame_done, frame_err, err_code, image_ready} !== '0) begin
      fails++;
      $display("FAIL %s: outputs busy=%b wr_en=%b addr=%0d data=%h len=%0d done=%b err=%b code=%0d ready=%b, required all 0",
               name, busy, wr_en, wr_addr, wr_data, frame_len, frame_done, frame_err, err_code, image_ready);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_zero("reset_mid_frame");
    fbuf.delete(); wq.delete(); eq.delete();
    m_img = 0; m_flen = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done && frame_err) begin
        tests++; fails++;
        $display("FAIL done_err_overlap: cycle %0d both frame_done and frame_err high, required exclusive", cyc);
      end
      if (wr_en) begin
        tests++;
        if (wq.size() == 0) begin
          fails++;
          $display("FAIL write: cycle %0d unexpected write addr=%0d data=%h, required none", cyc, wr_addr, wr_data);
        end else begin
          wr_t w;
          w = wq.pop_front();
          if (int'(wr_addr) != w.addr || int'(wr_data) != w.data || cyc != w.cyc) begin
            fails++;
            $display("FAIL write: got addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                     wr_addr, wr_data, cyc, w.addr, w.data, w.cyc);
          end else
            $display("[TB] write addr=%0d data=%h cycle=%0d ok", wr_addr, wr_data, cyc);
        end
      end
      if (frame_done || frame_err) begin
        tests++;
        if (eq.size() == 0) begin
          fails++;
          $display("FAIL event: cycle %0d unexpected done=%b err=%b code=%0d, required none",
                   cyc, frame_done, frame_err, err_code);
        end else begin
          ev_t e;
          int kind;
          e = eq.pop_front();
          kind = frame_done ? 1 : 2;
          if (kind != e.kind || int'(err_code) != e.code || cyc != e.cyc ||
              int'(image_ready) != e.img || int'(frame_len) != e.flen) begin
            fails++;
            $display("FAIL event: got kind=%0d code=%0d cycle=%0d ready=%b len=%0d, required kind=%0d code=%0d cycle=%0d ready=%0d len=%0d",
                     kind, err_code, cyc, image_ready, frame_len, e.kind, e.code, e.cyc, e.img, e.flen);
          end else
            $display("[TB] event kind=%0d code=%0d cycle=%0d len=%0d ok", kind, err_code, cyc, frame_len);
        end
      end
    end
  end

  initial begin
    logic [7:0] seq[$];
    int kind, len, sum, gap_at;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b0;
    @(negedge clk);

    seq = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    send_seq(seq, 0);
    seq = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0B};
    send_seq(seq, 0);
    seq = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h00};
    send_seq(seq, 1);
    seq = '{8'hA5, 8'h5A, 8'h02, 8'h4C, 8'h01};
    send_seq(seq, 1);
    // Timeout after two payload bytes, then the exact-expiry race.
    seq = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22};
    send_seq(seq, 0);
    idle_n(120);
    send_seq(seq, 0);
    idle_n(TO - 1);
    seq = '{8'h33, 8'h44, 8'hAA};
    send_seq(seq, 0);
    seq = '{8'h00, 8'hA5, 8'h3C, 8'hA5, 8'hA5, 8'h5A, 8'h00, 8'h00, 8'h01, 8'h7F, 8'h7F};
    send_seq(seq, 0);
    // Largest legal length is accepted, then abandoned by timeout.
    seq = '{8'hA5, 8'h5A, 8'h02, 8'h4C, 8'h00, 8'h99};
    send_seq(seq, 0);
    idle_n(110);
    // Reset mid-payload, then a good frame.
    seq = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h06, 8'h10, 8'h20, 8'h30};
    send_seq(seq, 0);
    tick_idle();
    do_reset();
    seq = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'h02, 8'hF0, 8'h20, 8'h10};
    send_seq(seq, 0);

    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 4);
      seq.delete();
      if (kind == 3) begin
        for (int i = 0; i < $urandom_range(1, 4); i++) seq.push_back(8'($urandom_range(0, 255)));
        send_seq(seq, 2);
      end else if (kind == 2) begin
        case ($urandom_range(0, 2))
          0: len = 0;
          1: len = MAX_BYTES + 1;
          default: len = 24'hFFFFFF;
        endcase
        seq = '{8'hA5, 8'h5A, 8'(len >> 16), 8'(len >> 8), 8'(len)};
        send_seq(seq, 2);
      end else begin
        len = $urandom_range(1, 6);
        seq = '{8'hA5, 8'h5A, 8'h00, 8'h00, 8'(len)};
        sum = 0;
        for (int i = 0; i < len; i++) begin
          seq.push_back(8'($urandom_range(0, 255)));
          sum += int'(seq[seq.size() - 1]);
        end
        seq.push_back(kind == 1 ? 8'(sum + 1) : 8'(sum));
        if (kind == 4) begin
          gap_at = $urandom_range(1, seq.size() - 1);
          foreach (seq[i]) begin
            if (i == gap_at) idle_n($urandom_range(TO - 3, TO + 3));
            send_byte(seq[i]);
          end
        end else begin
          send_seq(seq, 3);
        end
      end
    end

    idle_n(150);
    tests++;
    if (wq.size() != 0 || eq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d writes and %0d events outstanding, required 0 and 0", wq.size(), eq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
